store_size_rmw: RTL
===================

Name: store_size_rmw

Overview:
- Store-side counterpart of the load-size stage, sitting between register-file operand B and the data memory port.
- Executes sb/sh/sw as a memory access sequence.
- Word stores: single write.
- Byte/half stores: read-modify-write. Reads the addressed word, replaces the low byte or low halfword with the store operand, then writes back.
- Handshakes with the multicycle control unit via start/busy/done.

Parameters:
- MEM_LAT, 1, memory read latency in cycles from mem_addr valid to mem_rdata valid; legal range 1..15.
- CNT_W, 4, width of the latency counter; must hold MEM_LAT.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request from control unit; sampled only in IDLE.
- control  in  2  store size: 00 none, 01 byte, 10 half, 11 word (same encoding as load-size control).
- addr  in  32  byte address of the store.
- store_data  in  32  operand B value.
- mem_rdata  in  32  memory read data.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_wr  out  1  memory write strobe, 1 = write, 0 = read.
- busy  out  1  high from cycle after accepted start until done cycle inclusive.
- done  out  1  one-cycle completion pulse.

Behaviour:
- All outputs are registered.
- Reset, asynchronous, active-low:
  - state goes to IDLE, counter to 0.
  - mem_addr, mem_wdata, mem_wr, busy, done all go to 0.
- States: IDLE, RD_WAIT, WRITE, DONE.
- IDLE:
  - start=1 and control!=00: latch addr, control, store_data.
  - control=11: go to WRITE, with mem_wdata=store_data and mem_addr=addr.
  - control=01 or 10: go to RD_WAIT, with mem_addr=addr, mem_wr=0, counter=MEM_LAT.
  - start with control=00 is ignored: no busy, no done.
- RD_WAIT:
  - Counter decrements each cycle.
  - When counter==0, capture merged word into mem_wdata and go to WRITE.
  - Byte merge: {mem_rdata[31:8], store_data[7:0]}.
  - Half merge: {mem_rdata[31:16], store_data[15:0]}.
- WRITE: mem_wr=1 for exactly one cycle with the latched address, then go to DONE.
- DONE: done=1 for one cycle, busy still 1, then go to IDLE.
- Latency, with start sampled at edge 0:
  - Word: mem_wr high in cycle 1, done in cycle 2.
  - Byte/half: mem_wr high in cycle 2+MEM_LAT, done in cycle 3+MEM_LAT.
- start while busy is ignored; no queueing.
- mem_addr holds its last value in IDLE. mem_wr is 0 in every state except WRITE.
- The addr low bits are not used to select lanes; the merge is always into low lanes.
- Reset asserted mid-operation: the sequence aborts, and mem_wr drops immediately (asynchronous), so no partial write is issued afterwards.
- store_data and addr changing after start have no effect; the latched copies are used.

Optional Feature:
- Macro: STORE_ALIGN_CHECK_EN.
- Defined:
  - Adds output port misalign (1 bit, reset 0).
  - On start, misalignment is: half with addr[0]!=0, or word with addr[1:0]!=00.
  - A misaligned start goes directly to DONE with no memory access (mem_wr stays 0).
  - misalign=1 together with done.
- Undefined: no port and no check; all addresses proceed as normal.

Decomposition:
- Shared package store_pkg:
  - size encodings SZ_NONE/SZ_BYTE/SZ_HALF/SZ_WORD (shared with the load-size stage).
  - state enum.
  - MEM_LAT default constant.
- One sub-module, store_lane_merge: purely combinational (size, old word, new data) -> merged word; reused by the bench model.

Test Plan:
- Word store: reset released, start with control=11, addr=0x10, store_data=0xDEADBEEF -> cycle 1 mem_wr=1, mem_addr=0x10, mem_wdata=0xDEADBEEF; cycle 2 done=1; busy low by cycle 3.
- Byte store, MEM_LAT=1: memory word=0x11223344, store_data=0xAABBCCDD, control=01 -> single write of 0x112233DD at cycle 3, done cycle 4.
- Half store, MEM_LAT=3: memory=0x11223344, store_data=0x0000BEEF, control=10 -> write 0x1122BEEF at cycle 5, done cycle 6; no mem_wr before then.
- Start pulses during busy, plus start with control=00 in IDLE -> ignored; exactly one write and one done per accepted start.
- Reset dropped during RD_WAIT of a byte store -> all outputs 0 immediately, no write ever issued; a later word store completes normally.
- With STORE_ALIGN_CHECK_EN: half store at addr=0x21 -> done and misalign high in cycle 1, mem_wr never asserted.

Source files
------------

// File: rtl/store_pkg.sv
// store_pkg: size encodings shared with the load-size stage, store FSM states,
// and the default memory read latency.
package store_pkg;
    localparam int MEM_LAT_DEF = 1;

    typedef enum logic [1:0] {
        SZ_NONE = 2'b00,
        SZ_BYTE = 2'b01,
        SZ_HALF = 2'b10,
        SZ_WORD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_WAIT,
        S_WRITE,
        S_DONE
    } state_e;
endpackage

// File: rtl/store_lane_merge.sv
// store_lane_merge: places a byte/half store operand into the low lanes of the
// word read back from memory; word stores pass the operand through unchanged.
module store_lane_merge
    import store_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [31:0] i_old,
    input  logic [31:0] i_new,
    output logic [31:0] o_merged
);
    assign o_merged = (i_size == SZ_BYTE) ? {i_old[31:8], i_new[7:0]} :
                      (i_size == SZ_HALF) ? {i_old[31:16], i_new[15:0]} : i_new;
endmodule

// File: rtl/store_size_rmw.sv
// store_size_rmw: sb/sh/sw sequencer; word stores write once, byte/half stores read-modify-write.
// Defining STORE_ALIGN_CHECK_EN adds o_misalign and completes misaligned stores without memory access.
module store_size_rmw
    import store_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF,
    parameter int CNT_W   = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [1:0]  i_control,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_wr,
    output logic        o_busy,
    output logic        o_done
`ifdef STORE_ALIGN_CHECK_EN
    ,
    output logic        o_misalign
`endif
);
    state_e           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]       r_size;
    logic [31:0]      r_data, r_mem_addr, r_mem_wdata;
    logic [31:0]      w_merged, w_addr_nxt, w_wdata_nxt;
    logic             r_mem_wr, r_busy, r_done;
    logic             w_accept, w_mis, w_rd_last;
`ifdef STORE_ALIGN_CHECK_EN
    logic             r_misalign;
    assign w_mis      = (i_control == SZ_HALF && i_addr[0]) ||
                        (i_control == SZ_WORD && i_addr[1:0] != 2'b00);
    assign o_misalign = r_misalign;
`else
    assign w_mis = 1'b0;
`endif

    assign w_accept  = r_state == S_IDLE && i_start && i_control != SZ_NONE;
    assign w_rd_last = r_state == S_RD_WAIT && r_cnt == '0;

    store_lane_merge u_merge (
        .i_size   (r_size),
        .i_old    (i_mem_rdata),
        .i_new    (r_data),
        .o_merged (w_merged)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_size      <= SZ_NONE;
            r_data      <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wr    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef STORE_ALIGN_CHECK_EN
            r_misalign  <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_mem_addr  <= w_addr_nxt;
            r_mem_wdata <= w_wdata_nxt;
            r_mem_wr    <= w_state_nxt == S_WRITE;
            r_busy      <= w_state_nxt != S_IDLE;
            r_done      <= w_state_nxt == S_DONE;
            if (w_accept) begin
                r_size <= i_control;
                r_data <= i_store_data;
            end
`ifdef STORE_ALIGN_CHECK_EN
            r_misalign  <= w_accept && w_mis;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    w_state_nxt = !w_accept ? S_IDLE :
                                     w_mis ? S_DONE :
                                     i_control == SZ_WORD ? S_WRITE : S_RD_WAIT;
            S_RD_WAIT: w_state_nxt = r_cnt == '0 ? S_WRITE : S_RD_WAIT;
            S_WRITE:   w_state_nxt = S_DONE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // The counter reaches zero on the cycle the read data is due, which is when the merge is captured.
    always_comb begin
        w_cnt_nxt   = w_accept ? CNT_W'(MEM_LAT) :
                      (r_state == S_RD_WAIT && r_cnt != '0) ? r_cnt - CNT_W'(1) : r_cnt;
        w_addr_nxt  = (w_accept && !w_mis) ? i_addr : r_mem_addr;
        w_wdata_nxt = (w_accept && !w_mis && i_control == SZ_WORD) ? i_store_data :
                      w_rd_last ? w_merged : r_mem_wdata;
    end

    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_wr    = r_mem_wr;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
endmodule
